// File: rtl/ysyx_23060332_dmem_slave_pkg.sv
// Shared types and constants for the data-memory responder.
package ysyx_23060332_dmem_slave_pkg;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 64;
  localparam int MASK_W  = DATA_W / 8;
  localparam int WADDR_W = ADDR_W - 3;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_e;

  // Latched request; the byte offset is dropped because every access is a full aligned word.
  typedef struct packed {
    logic               wen;
    logic [WADDR_W-1:0] waddr;
    logic [DATA_W-1:0]  wdata;
    logic [MASK_W-1:0]  wmask;
  } dmem_req_t;

endpackage

// File: rtl/ysyx_23060332_dmem_slave_if.sv
// Request/response channels between the execute stage and the data-memory responder.
interface ysyx_23060332_dmem_slave_if;
  import ysyx_23060332_dmem_slave_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [MASK_W-1:0] req_wmask;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/ysyx_23060332_dmem_array.sv
// Single-port DEPTH x 64 storage: synchronous byte-masked write, combinational read.
module ysyx_23060332_dmem_array
  import ysyx_23060332_dmem_slave_pkg::*;
#(
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] idx_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [MASK_W-1:0]        wmask_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Byte-lane write: only enabled lanes of the addressed word change.
  // NOTE: the array has no reset; clearing 512 words would force flops instead of SRAM,
  //       and sequential state is always assigned with <= so reads in the same edge see old data.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < MASK_W; i++) begin
        if (wmask_i[i]) mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/ysyx_23060332_dmem_slave.sv
// Data-memory responder: accepts one request, waits LATENCY cycles, accesses the array,
// then holds the response until the requester takes it.
module ysyx_23060332_dmem_slave
  import ysyx_23060332_dmem_slave_pkg::*;
#(
  parameter int DEPTH   = 512,
  parameter int LATENCY = 2
) (
  input logic                       clk,
  input logic                       rst_n,
  ysyx_23060332_dmem_slave_if.slave bus
);

  localparam int               IDX_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

  dmem_state_e       state_q;
  logic [CNT_W-1:0]  cnt_q;
  dmem_req_t         req_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

  dmem_req_t         bus_req;
  dmem_req_t         acc_req;
  logic              commit;
  logic              in_range;
  logic              arr_we;
  logic [DATA_W-1:0] arr_rdata;
  logic [DATA_W-1:0] rdata_d;
  logic              err_d;
  logic              addr_lo_unused;

  assign bus_req = '{wen:   bus.req_wen,
                     waddr: bus.req_addr[ADDR_W-1:3],
                     wdata: bus.req_wdata,
                     wmask: bus.req_wmask};

  // With zero latency the access happens on the accept edge, so the live bus is used.
  assign acc_req  = (state_q == DMEM_IDLE) ? bus_req : req_q;
  assign commit   = ((state_q == DMEM_WAIT) && (cnt_q == '0)) ||
                    ((LATENCY == 0) && (state_q == DMEM_IDLE) && bus.req_valid);
  assign in_range = acc_req.waddr < WADDR_W'(DEPTH);
  assign arr_we   = commit && in_range && acc_req.wen;
  assign rdata_d  = (in_range && !acc_req.wen) ? arr_rdata : '0;
  assign err_d    = !in_range;

  assign addr_lo_unused = ^bus.req_addr[2:0];

  ysyx_23060332_dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk     (clk),
    .we_i    (arr_we),
    .idx_i   (acc_req.waddr[IDX_W-1:0]),
    .wdata_i (acc_req.wdata),
    .wmask_i (acc_req.wmask),
    .rdata_o (arr_rdata)
  );

  // Request FSM with latency counter, request latch and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= DMEM_IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        DMEM_IDLE: begin
          if (bus.req_valid) begin
            req_q       <= bus_req;
            req_ready_q <= 1'b0;
            if (LATENCY == 0) begin
              state_q     <= DMEM_RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= rdata_d;
              rsp_err_q   <= err_d;
            end else begin
              state_q <= DMEM_WAIT;
              cnt_q   <= CNT_LOAD;
            end
          end
        end
        DMEM_WAIT: begin
          if (cnt_q == '0) begin
            state_q     <= DMEM_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rdata_d;
            rsp_err_q   <= err_d;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DMEM_RESP: begin
          if (bus.rsp_ready) begin
            state_q     <= DMEM_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= DMEM_IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
